bus_decoder: RTL
================

BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 20: CPU address width.
REQ-002 Parameter SLOT_COUNT, default 8: number of peripheral slots; slot SLOT_COUNT-1 is the high (flash) region.
REQ-003 Parameter SLOT_SHIFT, default 16: LSB of the slot-index field.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: ACCESS cycles before fault; legal range 1..65535.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cpu_mem_valid  in  1  CPU request valid; held high until cpu_mem_ready is sampled.
REQ-008 cpu_address  in  ADDR_WIDTH  request address.
REQ-009 cpu_wstrb  in  4  byte write strobes; nonzero means write.
REQ-010 cpu_mem_ready  out  1  one-cycle completion pulse.
REQ-011 cpu_rdata  out  32  read data, valid while cpu_mem_ready is high.
REQ-012 bus_error  out  1  high with cpu_mem_ready when the access faulted.
REQ-013 slot_en  out  SLOT_COUNT  one-hot slot select, registered.
REQ-014 slot_write_en  out  SLOT_COUNT  slot_en qualified by write, registered.
REQ-015 slot_ready  in  SLOT_COUNT  per-slot completion.
REQ-016 slot_rdata  in  32*SLOT_COUNT  per-slot read data; slot k occupies bits [32k+31:32k].
REQ-017 fault_address  out  ADDR_WIDTH  address of the most recent faulted access, sticky.

Function
REQ-018 Decode: when cpu_address MSB is 1, the slot is SLOT_COUNT-1; otherwise the slot is cpu_address[SLOT_SHIFT +: clog2(SLOT_COUNT)].
REQ-019 Decode: MSB clear with index >= SLOT_COUNT-1, or any nonzero address bit between the index field and the MSB, is unmapped.
REQ-020 FSM states: IDLE, ACCESS, RESPOND.
REQ-021 IDLE with cpu_mem_valid high, mapped: latch the slot and write flag, raise slot_en/slot_write_en for that slot, clear the timer, go to ACCESS.
REQ-022 IDLE with cpu_mem_valid high, unmapped: go to RESPOND with the fault flag set and slot_en all zero.
REQ-023 ACCESS with slot_ready[slot] high: capture that slot's rdata, drop slot_en, go to RESPOND with no fault.
REQ-024 ACCESS with slot_ready low: increment the timer; when the timer equals TIMEOUT_CYCLES-1, go to RESPOND with the fault flag set and drop slot_en.
REQ-025 ACCESS with cpu_mem_valid low: abort to IDLE; drop slot_en; no cpu_mem_ready pulse.
REQ-026 RESPOND: assert cpu_mem_ready for exactly one cycle and return to IDLE.
REQ-027 RESPOND, fault: cpu_rdata = 32'h0 and bus_error = 1; fault_address loads the latched address.
REQ-028 Latency: valid sampled at edge N, ready sampled at edge N+1 gives cpu_mem_ready high during the cycle after edge N+2.
REQ-029 slot_ready on non-selected slots is ignored.
REQ-030 If slot_ready and timeout coincide, slot_ready wins (no fault).
REQ-031 cpu_rdata holds its last value outside RESPOND; writes return the captured slot rdata.

Reset
REQ-032 reset_n low immediately sets: state IDLE; slot_en, slot_write_en, cpu_mem_ready, bus_error, timer = 0; cpu_rdata = 0; fault_address = 0.
REQ-033 Reset mid-ACCESS drops slot_en asynchronously; the aborted request is never acknowledged.

Configuration
REQ-034 Macro BUS_DECODER_TIMEOUT_EN defined: the timer, timeout fault and fault_address are present as specified above.
REQ-035 Macro BUS_DECODER_TIMEOUT_EN undefined: ACCESS waits indefinitely; bus_error is tied 0; fault_address is tied 0.
REQ-036 Macro BUS_DECODER_TIMEOUT_EN undefined: unmapped accesses complete in RESPOND with cpu_rdata = 0.

Structure
REQ-037 Package bus_decoder_pkg holds the FSM state encoding, the fault read-data constant (32'h0) and the write-detect helper.
REQ-038 Sub-module bus_timeout_counter (clear, enable, terminal-count output) is instantiated only under BUS_DECODER_TIMEOUT_EN.

Verification
REQ-039 Read 0x10004 with slot 1 ready one cycle later, rdata 0x12345678 -> slot_en = 0x02, one ready pulse with rdata 0x12345678, bus_error = 0.
REQ-040 Write 0x20000 with wstrb 0xF -> slot_write_en = 0x04 until slot 2 ready; ready pulse; no error.
REQ-041 Read 0x80000 -> slot_en = 0x80 (flash slot).
REQ-042 Read 0x70000 -> slot_en stays 0; ready with bus_error = 1 and fault_address = 0x70000.
REQ-043 Read slot 3 with no slot_ready, macro defined, TIMEOUT_CYCLES = 4 -> ready with bus_error = 1 exactly 4 ACCESS cycles later; slot_ready and timeout on the same cycle -> no error.
REQ-044 Drop cpu_mem_valid mid-ACCESS, and separately pulse reset_n low mid-ACCESS -> slot_en clears, no ready pulse, and the next request decodes normally.

Source files
------------

// File: rtl/bus_decoder_pkg.sv
// ============================================================================
// Module      : bus_decoder_pkg
// Description : Shared FSM encoding, fault read-data constant and write-detect
//               helper for the bus_decoder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    localparam logic [31:0] C_FAULT_RDATA = 32'h0;

    function automatic logic is_write(input logic [3:0] wstrb);
        return |wstrb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_decoder_if.sv
// ============================================================================
// Module      : bus_decoder_if
// Description : CPU-side request/response and peripheral slot-side signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_decoder_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int SLOT_COUNT = 8
);
    logic                    cpu_mem_valid;
    logic [ADDR_WIDTH-1:0]   cpu_address;
    logic [3:0]              cpu_wstrb;
    logic                    cpu_mem_ready;
    logic [31:0]             cpu_rdata;
    logic                    bus_error;
    logic [SLOT_COUNT-1:0]   slot_en;
    logic [SLOT_COUNT-1:0]   slot_write_en;
    logic [SLOT_COUNT-1:0]   slot_ready;
    logic [32*SLOT_COUNT-1:0] slot_rdata;
    logic [ADDR_WIDTH-1:0]   fault_address;

    // Decoder side
    modport slave (
        input  cpu_mem_valid, cpu_address, cpu_wstrb, slot_ready, slot_rdata,
        output cpu_mem_ready, cpu_rdata, bus_error, slot_en, slot_write_en,
        output fault_address
    );

    // CPU / peripheral side
    modport master (
        output cpu_mem_valid, cpu_address, cpu_wstrb, slot_ready, slot_rdata,
        input  cpu_mem_ready, cpu_rdata, bus_error, slot_en, slot_write_en,
        input  fault_address
    );
endinterface

`default_nettype wire

// File: rtl/bus_timeout_counter.sv
// ============================================================================
// Module      : bus_timeout_counter
// Description : 16-bit access timer with clear, enable and terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);
    localparam logic [15:0] C_TERMINAL = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign terminal_o = (count_q == C_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/bus_decoder.sv
// ============================================================================
// Module      : bus_decoder
// Description : CPU-to-peripheral slot decoder with registered one-hot selects.
//               Define BUS_DECODER_TIMEOUT_EN for access timeout and fault report.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 20,
    parameter int SLOT_COUNT     = 8,
    parameter int SLOT_SHIFT     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_decoder_if.slave  bus
);
    localparam int IDX_W  = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
    localparam int GAP_LO = SLOT_SHIFT + IDX_W;
    localparam logic [IDX_W-1:0]      C_LAST_SLOT = IDX_W'(SLOT_COUNT - 1);
    localparam logic [SLOT_COUNT-1:0] C_ONE       = SLOT_COUNT'(1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       dec_slot, slot_q, slot_d;
    logic                   dec_mapped, dec_gap;
    logic                   write_q, write_d;
    logic                   fault_q, fault_d;
    logic [31:0]            cap_q, cap_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic [SLOT_COUNT-1:0]  slot_en_q, slot_en_d;
    logic [SLOT_COUNT-1:0]  wen_q, wen_d;
    logic                   accept, sel_ready, timeout;
    logic [31:0]            sel_rdata;

    always_comb begin
        dec_gap = 1'b0;
        for (int i = GAP_LO; i < ADDR_WIDTH - 1; i++) begin
            dec_gap = dec_gap | bus.cpu_address[i];
        end
        if (bus.cpu_address[ADDR_WIDTH-1]) begin
            dec_slot   = C_LAST_SLOT;
            dec_mapped = 1'b1;
        end else begin
            dec_slot   = bus.cpu_address[SLOT_SHIFT +: IDX_W];
            dec_mapped = !dec_gap && (dec_slot < C_LAST_SLOT);
        end
    end

    // The acknowledge cycle still sees the CPU's valid; it must not start a new access.
    assign accept    = bus.cpu_mem_valid && !ready_q;
    assign sel_ready = bus.slot_ready[slot_q];
    assign sel_rdata = bus.slot_rdata[{slot_q, 5'd0} +: 32];

`ifdef BUS_DECODER_TIMEOUT_EN
    logic tc;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (state_q != ST_ACCESS),
        .enable_i   ((state_q == ST_ACCESS) && !sel_ready),
        .terminal_o (tc)
    );

    assign timeout = tc;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = dec_mapped ? ST_ACCESS : ST_RESPOND;
                end
            end
            ST_ACCESS: begin
                if (!bus.cpu_mem_valid) begin
                    state_d = ST_IDLE;
                end else if (sel_ready || timeout) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        slot_d  = slot_q;
        write_d = write_q;
        fault_d = fault_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    slot_d  = dec_slot;
                    write_d = is_write(bus.cpu_wstrb);
                    fault_d = !dec_mapped;
                end
            end
            ST_ACCESS: begin
                if (bus.cpu_mem_valid) begin
                    if (sel_ready) begin
                        cap_d   = sel_rdata;
                        fault_d = 1'b0;
                    end else if (timeout) begin
                        fault_d = 1'b1;
                    end
                end
            end
            ST_RESPOND: begin
                ready_d = 1'b1;
                rdata_d = fault_q ? C_FAULT_RDATA : cap_q;
            end
            default: ;
        endcase
        slot_en_d = (state_d == ST_ACCESS) ? (C_ONE << slot_d) : '0;
        wen_d     = write_d ? slot_en_d : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q    <= '0;
            write_q   <= 1'b0;
            fault_q   <= 1'b0;
            cap_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            slot_en_q <= '0;
            wen_q     <= '0;
        end else begin
            slot_q    <= slot_d;
            write_q   <= write_d;
            fault_q   <= fault_d;
            cap_q     <= cap_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            slot_en_q <= slot_en_d;
            wen_q     <= wen_d;
        end
    end

`ifdef BUS_DECODER_TIMEOUT_EN
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] fault_addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q        <= 1'b0;
            addr_q       <= '0;
            fault_addr_q <= '0;
        end else begin
            err_q <= (state_q == ST_RESPOND) && fault_q;
            if ((state_q == ST_IDLE) && accept) begin
                addr_q <= bus.cpu_address;
            end
            if ((state_q == ST_RESPOND) && fault_q) begin
                fault_addr_q <= addr_q;
            end
        end
    end

    assign bus.bus_error     = err_q;
    assign bus.fault_address = fault_addr_q;
`else
    assign bus.bus_error     = 1'b0;
    assign bus.fault_address = '0;
`endif

    assign bus.cpu_mem_ready = ready_q;
    assign bus.cpu_rdata     = rdata_q;
    assign bus.slot_en       = slot_en_q;
    assign bus.slot_write_en = wen_q;

endmodule

`default_nettype wire
